// File: rtl/coin_transfer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | coin_transfer_ctrl: sequences player-RAM reads/writes for key/money  |
// | reads and validated coin transfers.                  Revision: 1.0   |
// +----------------------------------------------------------------------+
module coin_transfer_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [1:0] src,
  input  logic [1:0] dst,
  input  logic [7:0] amount,
  input  logic [7:0] key_in,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic [7:0] result,
  output logic [3:0] mem_addr,
  output logic       mem_wren,
  output logic [7:0] mem_data,
  input  logic [7:0] mem_q
);

  localparam logic [1:0] c_op_key   = 2'b01;
  localparam logic [1:0] c_op_money = 2'b10;
  localparam logic [1:0] c_op_xfer  = 2'b11;
  localparam logic [1:0] c_fld_key  = 2'b01;
  localparam logic [1:0] c_fld_mny  = 2'b10;
  localparam logic [1:0] c_st_ok    = 2'b00;
  localparam logic [1:0] c_st_key   = 2'b01;
  localparam logic [1:0] c_st_funds = 2'b10;
  localparam logic [1:0] c_st_inval = 2'b11;

  typedef enum logic [3:0] {
    IDLE = 4'd0, RQ = 4'd1, CP = 4'd2, RK = 4'd3, RS = 4'd4,
    RD   = 4'd5, CK = 4'd6, WS = 4'd7, WD = 4'd8, DN = 4'd9
  } state_t;

  state_t     r_state, w_next;
  logic [1:0] r_op, r_src, r_dst;
  logic [7:0] r_amount, r_key_claim, r_key_mem, r_src_bal, r_dst_bal;
  logic [1:0] w_ck_status, w_dn_status;
  logic [7:0] w_dn_result;
  logic [8:0] w_dst_sum;

  // Destination balance arrives on mem_q in CK and is evaluated directly.
  assign w_dst_sum = {1'b0, mem_q} + {1'b0, r_amount};

  always_comb begin
    w_ck_status = c_st_ok;
    if (r_src == r_dst)              w_ck_status = c_st_inval;
    else if (r_key_mem != r_key_claim) w_ck_status = c_st_key;
    else if (r_src_bal < r_amount)   w_ck_status = c_st_funds;
    else if (w_dst_sum[8])           w_ck_status = c_st_inval;
  end

  always_comb begin
    w_next      = r_state;
    w_dn_status = c_st_ok;
    w_dn_result = 8'h00;
    case (r_state)
      IDLE: begin
        if (start) begin
          case (op)
            c_op_key, c_op_money: w_next = RQ;
            c_op_xfer:            w_next = RK;
            default: begin
              w_next      = DN;
              w_dn_status = c_st_inval;
            end
          endcase
        end
      end
      RQ: w_next = CP;
      CP: begin
        w_next      = DN;
        w_dn_result = mem_q;
      end
      RK: w_next = RS;
      RS: w_next = RD;
      RD: w_next = CK;
      CK: begin
        if (w_ck_status == c_st_ok) begin
          w_next = WS;
        end else begin
          w_next      = DN;
          w_dn_status = w_ck_status;
          w_dn_result = r_src_bal;
        end
      end
      WS: w_next = WD;
      WD: begin
        w_next      = DN;
        w_dn_result = r_src_bal - r_amount;
      end
      DN:      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_op        <= 2'b00;
      r_src       <= 2'b00;
      r_dst       <= 2'b00;
      r_amount    <= 8'h00;
      r_key_claim <= 8'h00;
      r_key_mem   <= 8'h00;
      r_src_bal   <= 8'h00;
      r_dst_bal   <= 8'h00;
      status      <= 2'b00;
      result      <= 8'h00;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_op        <= op;
        r_src       <= src;
        r_dst       <= dst;
        r_amount    <= amount;
        r_key_claim <= key_in;
      end
      if (r_state == RS) r_key_mem <= mem_q;
      if (r_state == RD) r_src_bal <= mem_q;
      if (r_state == CK) r_dst_bal <= mem_q;
      // Outputs are loaded on entry to DN so they are visible with done.
      if (r_state != DN && w_next == DN) begin
        status <= w_dn_status;
        result <= w_dn_result;
      end
    end
  end

  always_comb begin
    mem_addr = 4'h0;
    mem_data = 8'h00;
    mem_wren = 1'b0;
    case (r_state)
      RQ: mem_addr = {r_src, r_op};
      RK: mem_addr = {r_dst, c_fld_key};
      RS: mem_addr = {r_src, c_fld_mny};
      RD: mem_addr = {r_dst, c_fld_mny};
      WS: begin
        mem_addr = {r_src, c_fld_mny};
        mem_data = r_src_bal - r_amount;
        mem_wren = ~reset;
      end
      WD: begin
        mem_addr = {r_dst, c_fld_mny};
        mem_data = r_dst_bal + r_amount;
        mem_wren = ~reset;
      end
      default: ;
    endcase
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DN);

endmodule
`default_nettype wire

// File: tb/tb_coin_transfer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_coin_transfer_ctrl: directed self-checking bench with RAM model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_coin_transfer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00, src = 2'b00, dst = 2'b00;
  logic [7:0] amount = 8'h00, key_in = 8'h00;
  logic       busy, done, mem_wren;
  logic [1:0] status;
  logic [7:0] result, mem_data;
  logic [3:0] mem_addr;
  logic [7:0] mem_q;

  coin_transfer_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src(src), .dst(dst),
    .amount(amount), .key_in(key_in), .busy(busy), .done(done),
    .status(status), .result(result), .mem_addr(mem_addr),
    .mem_wren(mem_wren), .mem_data(mem_data), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [16];
  logic [7:0] img [16];
  logic       load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) ram[i] <= img[i];
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_data;
    end
    mem_q <= ram[mem_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  int         first_done, second_done, n_done;
  logic [1:0] st_at_done;
  logic [7:0] res_at_done;
  logic [31:0] wr_mask;
  logic [3:0] addr_log [24];
  logic [7:0] data_log [24];
  logic       busy_log [24];
  logic       done_log [24];
  logic       wren_log [24];
  logic [1:0] stat_log [24];
  logic [7:0] res_log  [24];
  logic       wren_rst;

  task automatic preload(input logic [7:0] p2_money);
    @(negedge clk);
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    img[4'h5] = 8'h33;
    img[4'h6] = 8'd100;
    img[4'h9] = 8'h5A;
    img[4'hA] = p2_money;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  // Cycle 0 is the cycle in which start is first presented.
  task automatic issue(input logic [1:0] op_v, input logic [1:0] src_v,
                       input logic [1:0] dst_v, input logic [7:0] amt_v,
                       input logic [7:0] key_v, input int ncyc,
                       input logic [31:0] smask, input int rst_cyc);
    @(negedge clk);
    op = op_v; src = src_v; dst = dst_v; amount = amt_v; key_in = key_v;
    start = 1'b1;
    first_done = -1; second_done = -1; n_done = 0; wr_mask = 0;
    wren_rst = 1'bx;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      addr_log[c] = mem_addr; data_log[c] = mem_data; busy_log[c] = busy;
      done_log[c] = done; wren_log[c] = mem_wren;
      stat_log[c] = status; res_log[c] = result;
      if (mem_wren) wr_mask[c] = 1'b1;
      if (done) begin
        n_done++;
        if (first_done < 0) begin
          first_done = c; st_at_done = status; res_at_done = result;
        end else begin
          second_done = c;
        end
      end
      reset = 1'b0;
      start = smask[c];
      if (c == rst_cyc) begin
        reset = 1'b1;
        #1 wren_rst = mem_wren;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, status, result, mem_addr, mem_wren, mem_data} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_outputs got %h want 0",
               {busy, done, status, result, mem_addr, mem_wren, mem_data});
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle_busy got %b want 0", busy);
    end
  endtask

  task automatic test_transfer_ok;
    preload(8'd20);
    issue(2'b11, 2'd1, 2'd2, 8'd30, 8'h5A, 10, 32'h0, 0);
    n_cmp++;
    if (busy_log[1] !== 1'b1 || addr_log[1] !== 4'h9) begin
      n_bad++; $display("FAIL ok_cycle1 busy=%b addr=%h want 1/9", busy_log[1], addr_log[1]);
    end
    n_cmp++;
    if (wr_mask !== 32'h60) begin
      n_bad++; $display("FAIL ok_write_cycles got %h want 60", wr_mask);
    end
    n_cmp++;
    if (addr_log[5] !== 4'h6 || data_log[5] !== 8'd70 ||
        addr_log[6] !== 4'hA || data_log[6] !== 8'd50) begin
      n_bad++;
      $display("FAIL ok_write_data c5 %h=%0d c6 %h=%0d want 6=70 a=50",
               addr_log[5], data_log[5], addr_log[6], data_log[6]);
    end
    n_cmp++;
    if (first_done !== 7 || n_done !== 1 || st_at_done !== 2'b00 || res_at_done !== 8'd70) begin
      n_bad++;
      $display("FAIL ok_done cyc=%0d n=%0d st=%0d res=%0d want 7/1/0/70",
               first_done, n_done, st_at_done, res_at_done);
    end
    n_cmp++;
    if (ram[6] !== 8'd70 || ram[10] !== 8'd50) begin
      n_bad++; $display("FAIL ok_ram p1=%0d p2=%0d want 70/50", ram[6], ram[10]);
    end
    n_cmp++;
    if (stat_log[6] !== 2'b00 || res_log[6] !== 8'd0 || busy_log[8] !== 1'b0) begin
      n_bad++;
      $display("FAIL ok_hold st6=%0d res6=%0d busy8=%b want 0/0/0",
               stat_log[6], res_log[6], busy_log[8]);
    end
  endtask

  task automatic test_rejects;
    logic [7:0] p2m [4];
    logic [1:0] dsts [4];
    logic [7:0] amts [4];
    logic [7:0] keys [4];
    logic [1:0] exp_st [4];
    p2m[0] = 8'd20;  dsts[0] = 2'd2; amts[0] = 8'd30;  keys[0] = 8'h5B; exp_st[0] = 2'b01;
    p2m[1] = 8'd20;  dsts[1] = 2'd2; amts[1] = 8'd101; keys[1] = 8'h5A; exp_st[1] = 2'b10;
    p2m[2] = 8'd250; dsts[2] = 2'd2; amts[2] = 8'd10;  keys[2] = 8'h5A; exp_st[2] = 2'b11;
    p2m[3] = 8'd20;  dsts[3] = 2'd1; amts[3] = 8'd10;  keys[3] = 8'h33; exp_st[3] = 2'b11;
    for (int t = 0; t < 4; t++) begin
      preload(p2m[t]);
      issue(2'b11, 2'd1, dsts[t], amts[t], keys[t], 8, 32'h0, 0);
      n_cmp++;
      if (first_done !== 5 || n_done !== 1 || st_at_done !== exp_st[t] ||
          res_at_done !== 8'd100 || wr_mask !== 32'h0) begin
        n_bad++;
        $display("FAIL reject%0d cyc=%0d n=%0d st=%0d res=%0d wr=%h want 5/1/%0d/100/0",
                 t, first_done, n_done, st_at_done, res_at_done, wr_mask, exp_st[t]);
      end
      n_cmp++;
      if (ram[6] !== 8'd100 || ram[10] !== p2m[t] || ram[9] !== 8'h5A) begin
        n_bad++;
        $display("FAIL reject%0d_ram p1=%0d p2=%0d key=%h want 100/%0d/5a",
                 t, ram[6], ram[10], ram[9], p2m[t]);
      end
    end
  endtask

  task automatic test_reads;
    preload(8'd20);
    issue(2'b10, 2'd1, 2'd0, 8'd0, 8'h00, 5, 32'h0, 0);
    n_cmp++;
    if (addr_log[1] !== 4'h6 || addr_log[2] !== 4'h0 || first_done !== 3 ||
        st_at_done !== 2'b00 || res_at_done !== 8'd100) begin
      n_bad++;
      $display("FAIL read_money addr=%h cyc=%0d st=%0d res=%0d want 6/3/0/100",
               addr_log[1], first_done, st_at_done, res_at_done);
    end
    issue(2'b01, 2'd2, 2'd0, 8'd0, 8'h00, 5, 32'h0, 0);
    n_cmp++;
    if (addr_log[1] !== 4'h9 || first_done !== 3 || res_at_done !== 8'h5A) begin
      n_bad++;
      $display("FAIL read_key addr=%h cyc=%0d res=%h want 9/3/5a",
               addr_log[1], first_done, res_at_done);
    end
  endtask

  task automatic test_illegal_op;
    issue(2'b00, 2'd1, 2'd2, 8'd5, 8'h00, 4, 32'h0, 0);
    n_cmp++;
    if (first_done !== 1 || n_done !== 1 || st_at_done !== 2'b11 || wr_mask !== 32'h0) begin
      n_bad++;
      $display("FAIL illegal_op cyc=%0d n=%0d st=%0d wr=%h want 1/1/3/0",
               first_done, n_done, st_at_done, wr_mask);
    end
  endtask

  task automatic test_back_to_back;
    preload(8'd20);
    issue(2'b11, 2'd1, 2'd2, 8'd30, 8'h5A, 17, 32'h17C, 0);
    n_cmp++;
    if (first_done !== 7 || second_done !== 15 || n_done !== 2) begin
      n_bad++;
      $display("FAIL b2b_dones first=%0d second=%0d n=%0d want 7/15/2",
               first_done, second_done, n_done);
    end
    n_cmp++;
    if (busy_log[8] !== 1'b0 || busy_log[9] !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_busy c8=%b c9=%b want 0/1", busy_log[8], busy_log[9]);
    end
    n_cmp++;
    if (ram[6] !== 8'd40 || ram[10] !== 8'd80) begin
      n_bad++; $display("FAIL b2b_ram p1=%0d p2=%0d want 40/80", ram[6], ram[10]);
    end
  endtask

  task automatic test_reset_abort;
    preload(8'd20);
    // Reset lands in WD, after the WS debit has been written.
    issue(2'b11, 2'd1, 2'd2, 8'd30, 8'h5A, 10, 32'h0, 6);
    n_cmp++;
    if (wren_rst !== 1'b0) begin
      n_bad++; $display("FAIL abort_wren got %b want 0", wren_rst);
    end
    n_cmp++;
    if ({busy_log[7], done_log[7], stat_log[7], res_log[7], addr_log[7],
         wren_log[7], data_log[7]} !== 25'd0) begin
      n_bad++;
      $display("FAIL abort_outputs got %h want 0",
               {busy_log[7], done_log[7], stat_log[7], res_log[7], addr_log[7],
                wren_log[7], data_log[7]});
    end
    n_cmp++;
    if (n_done !== 0 || ram[6] !== 8'd70 || ram[10] !== 8'd20) begin
      n_bad++;
      $display("FAIL abort_ram n=%0d p1=%0d p2=%0d want 0/70/20", n_done, ram[6], ram[10]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    repeat (2) @(negedge clk);
    test_reset;
    test_transfer_ok;
    test_rejects;
    test_reads;
    test_illegal_op;
    test_back_to_back;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
